// File: rtl/range_avg_if.sv
// range_avg_if: bundles the result stream from maxmin and the
// block-result handshake toward the consumer of range_avg.
// master: the side that produces din/din_rdy and acknowledges blocks.
// slave : range_avg itself.
interface range_avg_if #(
  parameter int LOG2_N = 2
);
  logic [15:0]       din;
  logic              din_rdy;
  logic [15:0]       avg;
  logic [15:0]       peak;
  logic              vld;
  logic              ack;
  logic              ovf;
  logic [LOG2_N-1:0] cnt;

  modport master (
    output din, din_rdy, ack,
    input  avg, peak, vld, ovf, cnt
  );

  modport slave (
    input  din, din_rdy, ack,
    output avg, peak, vld, ovf, cnt
  );
endinterface

// File: rtl/range_avg.sv
// range_avg: averages blocks of N = 2^LOG2_N range results coming from
// maxmin and publishes the truncated average (and optionally the peak)
// through a vld/ack handshake. A block finished while the previous one
// is still unacknowledged is dropped and latches the sticky ovf flag.
// Optional feature macro: RANGE_AVG_PEAK_EN (running max and peak output).
// Without it, peak is tied to zero and no running-max register exists.
module range_avg #(
  parameter int LOG2_N = 2
) (
  input logic         clk,
  input logic         rst,
  range_avg_if.slave  bus
);

  localparam int DATA_W = 16;
  localparam int SUM_W  = DATA_W + LOG2_N;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_nxt;

  logic [SUM_W-1:0]  sum_p0;
  logic [SUM_W-1:0]  sum_nxt;
  logic [LOG2_N-1:0] cnt_p0;
  logic              blk_done;
  logic [DATA_W-1:0] blk_avg;

  logic [DATA_W-1:0] avg_p1;
  logic              ovf_p1;
  logic              load_out;
  logic              set_ovf;

  // Truncating divide by N: drop the LOG2_N fractional bits of the sum.
  function automatic logic [DATA_W-1:0] trunc_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_N];
  endfunction

  // Unsigned maximum of two results.
  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Block completes on the strobe carrying result N-1 (cnt all ones).
  assign blk_done = bus.din_rdy && (cnt_p0 == {LOG2_N{1'b1}});
  assign sum_nxt  = sum_p0 + SUM_W'(bus.din);
  assign blk_avg  = trunc_avg(sum_nxt);

  // Stage p0: running sum and result counter; both restart with no gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_p0 <= '0;
      cnt_p0 <= '0;
    end else if (bus.din_rdy) begin
      if (blk_done) begin
        sum_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        sum_p0 <= sum_nxt;
        cnt_p0 <= cnt_p0 + LOG2_N'(1);
      end
    end
  end

`ifdef RANGE_AVG_PEAK_EN
  logic [DATA_W-1:0] max_p0;
  logic [DATA_W-1:0] blk_peak;
  logic [DATA_W-1:0] peak_p1;

  assign blk_peak = max_u(max_p0, bus.din);

  // Stage p0: running maximum of the current block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_p0 <= '0;
    end else if (bus.din_rdy) begin
      max_p0 <= blk_done ? '0 : blk_peak;
    end
  end

  // Stage p1: published peak, loaded together with the average.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_p1 <= '0;
    end else if (load_out) begin
      peak_p1 <= blk_peak;
    end
  end

  assign bus.peak = peak_p1;
`else
  assign bus.peak = '0;
`endif

  // Output handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: load on completion unless a full, unacked block is held.
  always_comb begin
    state_nxt = state_q;
    load_out  = 1'b0;
    set_ovf   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (blk_done) begin
          load_out  = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (blk_done && bus.ack) begin
          load_out = 1'b1;
        end else if (blk_done) begin
          set_ovf = 1'b1;
        end else if (bus.ack) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p1: published average and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else begin
      if (load_out) avg_p1 <= blk_avg;
      if (set_ovf)  ovf_p1 <= 1'b1;
    end
  end

  assign bus.avg = avg_p1;
  assign bus.vld = (state_q == FULL);
  assign bus.ovf = ovf_p1;
  assign bus.cnt = cnt_p0;

endmodule

// File: tb/tb_range_avg.sv
// tb_range_avg: directed vectors with hand-computed expectations for
// range_avg at LOG2_N = 2. Peak expectations follow RANGE_AVG_PEAK_EN.
module tb_range_avg;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  range_avg_if #(.LOG2_N(2)) bus ();

  range_avg #(.LOG2_N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected peak for the current build.
  function automatic logic [31:0] pk(input logic [31:0] v);
`ifdef RANGE_AVG_PEAK_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe with the given result.
  task automatic strobe(input logic [15:0] v);
    bus.din     = v;
    bus.din_rdy = 1'b1;
    tick();
    bus.din_rdy = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] p,
                           input logic [31:0] v, input logic [31:0] o);
    chk({tag, ".avg"},  32'(bus.avg),  a);
    chk({tag, ".peak"}, 32'(bus.peak), pk(p));
    chk({tag, ".vld"},  32'(bus.vld),  v);
    chk({tag, ".ovf"},  32'(bus.ovf),  o);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    bus.din     = '0;
    bus.din_rdy = 1'b0;
    bus.ack     = 1'b0;

    // Reset state
    tick();
    tick();
    check_out("reset", 0, 0, 0, 0);
    chk("reset.cnt", 32'(bus.cnt), 0);
    rst = 1'b1;
    tick();

    // Block 31,10,20,40 every 2 cycles: avg = 101/4 = 25, peak 40
    strobe(16'd31); tick();
    strobe(16'd10); tick();
    chk("blk1.cnt_mid", 32'(bus.cnt), 2);
    strobe(16'd20); tick();
    strobe(16'd40);
    check_out("blk1", 25, 40, 1, 0);
    chk("blk1.cnt", 32'(bus.cnt), 0);

    // Hold 10 cycles without ack
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("hold", 25, 40, 1, 0);
    end

    // Ack alone while FULL: vld falls
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_out("ack1", 25, 40, 0, 0);

    // Ack while EMPTY has no effect
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_out("ack_empty", 25, 40, 0, 0);

    // Block 4,4,4,4 to get FULL again
    for (int i = 0; i < 4; i++) strobe(16'd4);
    check_out("blk4", 4, 4, 1, 0);

    // 65535 x4 back-to-back, ack on the 4th-strobe edge while FULL
    bus.din     = 16'hFFFF;
    bus.din_rdy = 1'b1;
    tick(); tick(); tick();
    bus.ack = 1'b1;
    tick();
    bus.din_rdy = 1'b0;
    bus.ack     = 1'b0;
    check_out("simul", 65535, 65535, 1, 0);
    chk("simul.cnt", 32'(bus.cnt), 0);

    // Drop: block 1,1,1,1 without ack keeps old outputs, sets ovf
    for (int i = 0; i < 4; i++) begin
      strobe(16'd1);
      tick();
    end
    check_out("drop", 65535, 65535, 1, 1);

    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_out("drop_ack", 65535, 65535, 0, 1);

    // Reset mid-block: partial 100,200 discarded
    strobe(16'd100);
    strobe(16'd200);
    chk("mid.cnt", 32'(bus.cnt), 2);
    rst = 1'b0;
    #1;
    check_out("in_reset", 0, 0, 0, 0);
    chk("in_reset.cnt", 32'(bus.cnt), 0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(16'd8);
    check_out("after_reset", 8, 8, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/range_avg.md
# range_avg

Downstream consumer of the 16-sample max/min range stage. Takes each range result from `maxmin` (16-bit `dout` qualified by its one-cycle `rdy` pulse) and accumulates N consecutive results. Publishes the truncated average and the peak range per block of N through a valid/ack handshake. Flags, with a sticky bit, any block lost because the consumer had not acknowledged the previous one.

## Interface

Parameters:
- `LOG2_N`, default 2: block size N = 2^LOG2_N results; legal 1..8.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-low; 0 forces reset state immediately.
- `din`  in  16: range result from upstream, unsigned.
- `din_rdy`  in  1: upstream result strobe; `din` valid on any cycle it is 1 (normally 1-cycle pulse, back-to-back legal).
- `avg`  out  16: floor(sum of block / N).
- `peak`  out  16: max `din` of the block.
- `vld`  out  1: `avg`/`peak` hold an unacknowledged block.
- `ack`  in  1: consumer accepts current block.
- `ovf`  out  1: sticky; a completed block was dropped.
- `cnt`  out  LOG2_N: results accumulated in the current block.

## Operation

Reset values:
- `avg`, `peak`, `cnt`, sum register, running max = 0.
- `vld` = 0, `ovf` = 0.

Accumulator:
- Sum register width 16+LOG2_N bits; cannot overflow.
- On each cycle with `din_rdy`=1: sum += `din`; running max = max(running max, `din`) unsigned; `cnt` += 1.
- Result `din` with `cnt` = N-1 completes the block:
  - block average = (sum + `din`) >> LOG2_N;
  - block peak = max(running max, `din`);
  - sum, running max, `cnt` clear to 0 on the same edge, so the next `din_rdy` starts a fresh block with no gap.

Output state machine, two states:
- EMPTY (`vld`=0):
  - On block completion: load `avg`/`peak`; go FULL.
  - `ack` ignored.
- FULL (`vld`=1); `avg`/`peak` held stable.
  - `ack`=1, no completion: go EMPTY.
  - `ack`=1 with completion on the same edge: load new block, stay FULL, `ovf` unchanged.
  - `ack`=0 with completion: new block dropped, old `avg`/`peak` kept, `ovf` <= 1, stay FULL.
- `ovf` clears only on reset.
- Accumulation never stalls; `din_rdy` is always accepted.

## Timing

- `avg`/`peak`/`vld` update on the edge that samples the N-th `din_rdy`. Latency is 1 cycle from the final strobe.
- `vld` falls on the edge sampling `ack`=1, unless a completion coincides.
- `ack` while `vld`=0 has no effect.
- Reset asserted mid-block discards the partial block. After release, the first `din_rdy` is result 0 of a new block.

## Configuration

- `RANGE_AVG_PEAK_EN` defined:
  - Running-max register and `peak` logic compiled in, as above.
- Not defined:
  - No running-max register.
  - `peak` is tied to 16'd0.
  - All other behaviour unchanged.

## Test plan

- Reset, LOG2_N=2:
  - Stimulus: `din_rdy` pulses with `din` = 31, 10, 20, 40, every 2 cycles.
  - Response: 1 cycle after the 4th pulse, `vld`=1, `avg`=25, `peak`=40, `cnt`=0, `ovf`=0.
- Hold then ack:
  - Stimulus: leave `vld`=1 for 10 cycles, then `ack`=1 for one cycle.
  - Response: `avg`=25/`peak`=40 stable throughout; `vld`=0 next cycle.
- Drop:
  - Stimulus: without `ack`, complete a second block of 1, 1, 1, 1.
  - Response: `avg` stays 25, `ovf`=1 thereafter; after `ack`, `ovf` still 1.
- Simultaneous ack and completion:
  - Stimulus: block of 65535 ×4, back-to-back strobes; `ack` asserted on the 4th-strobe edge while FULL.
  - Response: `avg`=65535, `peak`=65535, `vld` stays 1, `ovf` unchanged.
- Reset mid-block:
  - Stimulus: 2 results (100, 200), `rst`=0 for one cycle, then 4 results of 8.
  - Response: outputs 0 during reset; then `avg`=8, `peak`=8.
- Build without `RANGE_AVG_PEAK_EN`:
  - Stimulus: repeat the first scenario.
  - Response: `avg`=25, `peak`=0.
